// File: rtl/zsdram_line_prefetch.sv
// Display-side SDRAM prefetcher: fetches the frame buffer in 4-word bursts
// and presents pixels through a show-ahead FIFO to the LCD timing generator.
module zsdram_line_prefetch #(
    parameter int          H_PIXELS   = 480,
    parameter int          V_LINES    = 272,
    parameter logic [23:0] FB_BASE    = 24'h000000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          iFrame_Start,
    input  logic                          iPix_Rd,
    output logic [15:0]                   oPix_Data,
    output logic                          oPix_Valid,
    output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level,
    output logic                          oUnderflow,
    output logic                          oRd_Req,
    output logic [23:0]                   oRd_Addr,
    input  logic                          iRd_Done,
    input  logic [15:0]                   iRd_Data1,
    input  logic [15:0]                   iRd_Data2,
    input  logic [15:0]                   iRd_Data3,
    input  logic [15:0]                   iRd_Data4
);

    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam int          LW          = PW + 1;
    localparam logic [23:0] FRAME_WORDS = 24'(H_PIXELS * V_LINES);
    localparam logic [23:0] LAST_ADDR   = FB_BASE + FRAME_WORDS - 24'd4;
    localparam logic [LW-1:0] REQ_THRESH = LW'(FIFO_DEPTH - 4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        PUSH0 = 3'd2,
        PUSH1 = 3'd3,
        PUSH2 = 3'd4,
        PUSH3 = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [23:0]        addr_q, addr_d;
    logic               discard_q, discard_d;
    logic [3:0][15:0]   hold_q, hold_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               underflow_q, underflow_d;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic               push_s;
    logic [15:0]        push_data_s;
    logic               pop_s;
    logic               valid_s;
    logic [23:0]        next_addr_s;

    assign valid_s     = (level_q != {LW{1'b0}});
    assign next_addr_s = (addr_q == LAST_ADDR) ? FB_BASE : (addr_q + 24'd4);

    // Burst FSM: request issue, done capture, word-by-word push, frame restart.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        hold_d      = hold_q;
        push_s      = 1'b0;
        push_data_s = 16'h0000;
        case (state_q)
            IDLE: begin
                if (level_q <= REQ_THRESH) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (iRd_Done) begin
                    req_d = 1'b0;
                    if (discard_q || iFrame_Start) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        hold_d  = {iRd_Data4, iRd_Data3, iRd_Data2, iRd_Data1};
                        addr_d  = next_addr_s;
                        state_d = PUSH0;
                    end
                end else if (iFrame_Start) begin
                    // The mux transaction is already in flight: keep asking, drop its data later.
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            PUSH0: begin
                push_s      = ~iFrame_Start;
                push_data_s = hold_q[0];
                state_d     = iFrame_Start ? IDLE : PUSH1;
            end
            PUSH1: begin
                push_s      = ~iFrame_Start;
                push_data_s = hold_q[1];
                state_d     = iFrame_Start ? IDLE : PUSH2;
            end
            PUSH2: begin
                push_s      = ~iFrame_Start;
                push_data_s = hold_q[2];
                state_d     = iFrame_Start ? IDLE : PUSH3;
            end
            PUSH3: begin
                push_s      = ~iFrame_Start;
                push_data_s = hold_q[3];
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (iFrame_Start) begin
            addr_d = FB_BASE;
        end else begin
            addr_d = addr_d;
        end
    end

    // FIFO pointers, occupancy and sticky underflow.
    always_comb begin
        pop_s       = iPix_Rd & valid_s & ~iFrame_Start;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        if (iFrame_Start) begin
            wr_ptr_d    = {PW{1'b0}};
            rd_ptr_d    = {PW{1'b0}};
            level_d     = {LW{1'b0}};
            underflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            level_d = level_q + LW'(push_s) - LW'(pop_s);
            if (iPix_Rd && !valid_s) begin
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end
        end
    end

    // Control and FIFO state registers, frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= FB_BASE;
            discard_q   <= 1'b0;
            hold_q      <= '0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {LW{1'b0}};
            underflow_q <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            hold_q      <= hold_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Pixel storage; contents are only visible through the occupancy-qualified head.
    always_ff @(posedge clk) begin
        if (en && push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign oPix_Data   = valid_s ? mem_q[rd_ptr_q] : 16'h0000;
    assign oPix_Valid  = valid_s;
    assign oFifo_Level = level_q;
    assign oUnderflow  = underflow_q;
    assign oRd_Req     = req_q;
    assign oRd_Addr    = addr_q;

endmodule

// File: tb/tb_zsdram_line_prefetch.sv
// Scoreboard bench for zsdram_line_prefetch with a small 32-word frame so the
// address wrap is reached quickly; the responder returns done 3 cycles after req.
module tb_zsdram_line_prefetch;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        iFrame_Start = 1'b0;
    logic        iPix_Rd = 1'b0;
    logic [15:0] oPix_Data;
    logic        oPix_Valid;
    logic [4:0]  oFifo_Level;
    logic        oUnderflow;
    logic        oRd_Req;
    logic [23:0] oRd_Addr;
    logic        iRd_Done = 1'b0;
    logic [15:0] iRd_Data1 = 16'h0, iRd_Data2 = 16'h0, iRd_Data3 = 16'h0, iRd_Data4 = 16'h0;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    int          exp_rd = 0;
    logic [23:0] addr_log[$];
    bit          resp_on = 1'b0;
    int          disc_req = 0;
    int          disc_done = 0;
    bit          last_discard = 1'b0;
    int          wait_cnt = 0;

    zsdram_line_prefetch #(
        .H_PIXELS(H), .V_LINES(V), .FB_BASE(24'h000000), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .iFrame_Start(iFrame_Start),
        .iPix_Rd(iPix_Rd), .oPix_Data(oPix_Data), .oPix_Valid(oPix_Valid),
        .oFifo_Level(oFifo_Level), .oUnderflow(oUnderflow), .oRd_Req(oRd_Req),
        .oRd_Addr(oRd_Addr), .iRd_Done(iRd_Done), .iRd_Data1(iRd_Data1),
        .iRd_Data2(iRd_Data2), .iRd_Data3(iRd_Data3), .iRd_Data4(iRd_Data4)
    );

    always #5 clk = ~clk;

    // Multiplexer model: done three cycles after req, data = address + word index.
    always begin
        @(posedge clk);
        #1;
        if (iRd_Done) begin
            iRd_Done = 1'b0;
        end else if (resp_on && en && oRd_Req) begin
            wait_cnt++;
            if (wait_cnt == 3) begin
                wait_cnt  = 0;
                iRd_Done  = 1'b1;
                iRd_Data1 = oRd_Addr[15:0];
                iRd_Data2 = oRd_Addr[15:0] + 16'd1;
                iRd_Data3 = oRd_Addr[15:0] + 16'd2;
                iRd_Data4 = oRd_Addr[15:0] + 16'd3;
                if (disc_done != disc_req) begin
                    disc_done++;
                    last_discard = 1'b1;
                end else begin
                    last_discard = 1'b0;
                    addr_log.push_back(oRd_Addr);
                    for (int k = 0; k < 4; k++) exp_q.push_back(oRd_Addr[15:0] + 16'(k));
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (oRd_Req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", oRd_Req); end
        total++; if (oRd_Addr !== 24'h0) begin bad++; $display("FAIL reset_addr: got %h want 000000", oRd_Addr); end
        total++; if (oPix_Data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", oPix_Data); end
        total++; if (oPix_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", oPix_Valid); end
        total++; if (oFifo_Level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", oFifo_Level); end
        total++; if (oUnderflow !== 1'b0) begin bad++; $display("FAIL reset_underflow: got %b want 0", oUnderflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        bit saw_req = 1'b0;
        en = 1'b1;
        resp_on = 1'b1;
        for (int n = 0; n < 300 && oFifo_Level !== 5'd16; n++) @(negedge clk);
        total++; if (oFifo_Level !== 5'd16) begin bad++; $display("FAIL fill_level: got %0d want 16", oFifo_Level); end
        repeat (20) begin
            @(negedge clk);
            if (oRd_Req !== 1'b0) saw_req = 1'b1;
        end
        total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL fill_no_req: got req=%b want 0 while full", saw_req); end
        total++; if (addr_log.size() != 4) begin bad++; $display("FAIL fill_bursts: got %0d want 4", addr_log.size()); end
        for (int j = 0; j < 4 && j < addr_log.size(); j++) begin
            total++;
            if (addr_log[j] !== 24'(j * 4)) begin bad++; $display("FAIL fill_addr%0d: got %h want %h", j, addr_log[j], 24'(j * 4)); end
        end
        total++; if (oPix_Valid !== 1'b1 || oPix_Data !== 16'h0000) begin
            bad++; $display("FAIL fill_head: got valid=%b data=%h want 1/0000", oPix_Valid, oPix_Data);
        end
    endtask

    task automatic test_pop_stream();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++;
            if (oPix_Valid !== 1'b1 || exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                bad++; $display("FAIL stream_word%0d: got valid=%b data=%h want valid word %0d", i, oPix_Valid, oPix_Data, exp_rd);
            end
            if (i == 3 || i == 4) begin
                total++;
                if (oFifo_Level !== 5'(16 - i) || oRd_Req !== 1'b0) begin
                    bad++; $display("FAIL stream_thresh%0d: got level=%0d req=%b want %0d/0", i, oFifo_Level, oRd_Req, 16 - i);
                end
            end
            if (i == 5) begin
                total++; if (oRd_Req !== 1'b1) begin bad++; $display("FAIL stream_rereq: got %b want 1", oRd_Req); end
            end
            exp_rd++;
            iPix_Rd = 1'b1;
        end
        repeat (300) begin
            @(negedge clk);
            if (oPix_Valid) begin
                total++;
                if (exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                    bad++; $display("FAIL stream_data: got %h at word %0d", oPix_Data, exp_rd);
                end
                exp_rd++;
                iPix_Rd = 1'b1;
            end else begin
                iPix_Rd = 1'b0;
            end
        end
        @(negedge clk);
        iPix_Rd = 1'b0;
        total++; if (oUnderflow !== 1'b0) begin bad++; $display("FAIL stream_underflow: got %b want 0", oUnderflow); end
    endtask

    task automatic test_wrap();
        total++;
        if (addr_log.size() <= FRAME / 4 + 1) begin
            bad++; $display("FAIL wrap_count: got %0d bursts want more than %0d", addr_log.size(), FRAME / 4 + 1);
        end
        for (int j = 0; j < addr_log.size(); j++) begin
            total++;
            if (addr_log[j] !== 24'((j * 4) % FRAME)) begin
                bad++; $display("FAIL wrap_addr%0d: got %h want %h", j, addr_log[j], 24'((j * 4) % FRAME));
            end
        end
    endtask

    task automatic test_enable_freeze();
        int outstanding;
        resp_on = 1'b0;
        repeat (8) @(negedge clk);
        outstanding = exp_q.size() - exp_rd;
        total++; if (int'(oFifo_Level) != outstanding) begin bad++; $display("FAIL freeze_pre_level: got %0d want %0d", oFifo_Level, outstanding); end
        @(posedge clk); #1;
        en = 1'b0; iFrame_Start = 1'b1; iPix_Rd = 1'b1;
        @(posedge clk); #1;
        iFrame_Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        iPix_Rd = 1'b0;
        en = 1'b1;
        @(negedge clk);
        total++; if (int'(oFifo_Level) != outstanding) begin bad++; $display("FAIL freeze_level: got %0d want %0d", oFifo_Level, outstanding); end
        total++; if (oUnderflow !== 1'b0) begin bad++; $display("FAIL freeze_underflow: got %b want 0", oUnderflow); end
        total++; if (outstanding > 0 && oPix_Data !== exp_q[exp_rd]) begin bad++; $display("FAIL freeze_head: got %h want %h", oPix_Data, exp_q[exp_rd]); end
    endtask

    task automatic test_frame_start_req();
        for (int n = 0; n < 40 && !oRd_Req; n++) begin
            @(negedge clk);
            if (oPix_Valid) begin
                total++;
                if (exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                    bad++; $display("FAIL fsreq_drain: got %h at word %0d", oPix_Data, exp_rd);
                end
                exp_rd++;
                iPix_Rd = 1'b1;
            end else begin
                iPix_Rd = 1'b0;
            end
        end
        @(negedge clk);
        iPix_Rd = 1'b0;
        total++; if (oRd_Req !== 1'b1) begin bad++; $display("FAIL fsreq_wait_req: got %b want 1", oRd_Req); end
        @(posedge clk); #1;
        iFrame_Start = 1'b1;
        exp_rd = exp_q.size();
        disc_req++;
        @(posedge clk); #1;
        iFrame_Start = 1'b0;
        @(negedge clk);
        total++; if (oFifo_Level !== 5'd0 || oPix_Valid !== 1'b0 || oPix_Data !== 16'h0) begin
            bad++; $display("FAIL fsreq_flush: got level=%0d valid=%b data=%h want 0/0/0000", oFifo_Level, oPix_Valid, oPix_Data);
        end
        total++; if (oRd_Req !== 1'b1 || oRd_Addr !== 24'h0) begin
            bad++; $display("FAIL fsreq_hold: got req=%b addr=%h want 1/000000", oRd_Req, oRd_Addr);
        end
        repeat (4) @(negedge clk);
        total++; if (oRd_Req !== 1'b1) begin bad++; $display("FAIL fsreq_held: got %b want 1", oRd_Req); end
        resp_on = 1'b1;
        for (int n = 0; n < 10 && iRd_Done !== 1'b1; n++) @(negedge clk);
        total++; if (iRd_Done !== 1'b1) begin bad++; $display("FAIL fsreq_done_timeout: got %b want 1", iRd_Done); end
        @(negedge clk);
        total++; if (oRd_Req !== 1'b0 || oFifo_Level !== 5'd0) begin
            bad++; $display("FAIL fsreq_drop: got req=%b level=%0d want 0/0", oRd_Req, oFifo_Level);
        end
        @(negedge clk);
        total++; if (oFifo_Level !== 5'd0 || oRd_Req !== 1'b1 || oRd_Addr !== 24'h0) begin
            bad++; $display("FAIL fsreq_restart: got level=%0d req=%b addr=%h want 0/1/000000", oFifo_Level, oRd_Req, oRd_Addr);
        end
        for (int n = 0; n < 30 && oFifo_Level < 5'd4; n++) @(negedge clk);
        total++; if (addr_log.size() == 0 || addr_log[addr_log.size() - 1] !== 24'h0) begin
            bad++; $display("FAIL fsreq_base: got last burst not at 000000 (log size %0d)", addr_log.size());
        end
        total++; if (oPix_Data !== 16'h0000 || oPix_Valid !== 1'b1) begin
            bad++; $display("FAIL fsreq_first: got valid=%b data=%h want 1/0000", oPix_Valid, oPix_Data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (oPix_Valid !== 1'b1 || exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                bad++; $display("FAIL fsreq_word%0d: got valid=%b data=%h", i, oPix_Valid, oPix_Data);
            end
            exp_rd++;
            iPix_Rd = 1'b1;
        end
        @(negedge clk);
        iPix_Rd = 1'b0;
    endtask

    task automatic test_underflow();
        resp_on = 1'b0;
        repeat (8) @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (oPix_Valid) begin
                total++;
                if (exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                    bad++; $display("FAIL uf_drain: got %h at word %0d", oPix_Data, exp_rd);
                end
                exp_rd++;
                iPix_Rd = 1'b1;
            end else begin
                iPix_Rd = 1'b0;
                break;
            end
        end
        total++; if (oUnderflow !== 1'b0 || oPix_Valid !== 1'b0) begin
            bad++; $display("FAIL uf_pre: got underflow=%b valid=%b want 0/0", oUnderflow, oPix_Valid);
        end
        @(negedge clk);
        iPix_Rd = 1'b1;
        @(negedge clk);
        iPix_Rd = 1'b0;
        total++; if (oUnderflow !== 1'b1 || oFifo_Level !== 5'd0) begin
            bad++; $display("FAIL uf_set: got underflow=%b level=%0d want 1/0", oUnderflow, oFifo_Level);
        end
        resp_on = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (oPix_Valid) begin
                total++;
                if (exp_rd >= exp_q.size() || oPix_Data !== exp_q[exp_rd]) begin
                    bad++; $display("FAIL uf_traffic: got %h at word %0d", oPix_Data, exp_rd);
                end
                exp_rd++;
                iPix_Rd = 1'b1;
            end else begin
                iPix_Rd = 1'b0;
            end
        end
        @(negedge clk);
        iPix_Rd = 1'b0;
        total++; if (oUnderflow !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", oUnderflow); end
        resp_on = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        iFrame_Start = 1'b1;
        if (oRd_Req) disc_req++;
        exp_rd = exp_q.size();
        @(posedge clk); #1;
        iFrame_Start = 1'b0;
        @(negedge clk);
        total++; if (oUnderflow !== 1'b0 || oFifo_Level !== 5'd0) begin
            bad++; $display("FAIL uf_clear: got underflow=%b level=%0d want 0/0", oUnderflow, oFifo_Level);
        end
    endtask

    task automatic test_reset_mid_push();
        resp_on = 1'b1;
        for (int n = 0; n < 40 && !(iRd_Done === 1'b1 && !last_discard); n++) @(negedge clk);
        total++; if (!(iRd_Done === 1'b1 && !last_discard)) begin bad++; $display("FAIL rst_done_timeout: got done=%b want 1", iRd_Done); end
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (oFifo_Level !== 5'd1) begin bad++; $display("FAIL rst_pre_level: got %0d want 1", oFifo_Level); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (oRd_Req !== 1'b0 || oRd_Addr !== 24'h0) begin
            bad++; $display("FAIL rst_async_ctrl: got req=%b addr=%h want 0/000000", oRd_Req, oRd_Addr);
        end
        total++; if (oPix_Data !== 16'h0 || oPix_Valid !== 1'b0 || oFifo_Level !== 5'd0 || oUnderflow !== 1'b0) begin
            bad++; $display("FAIL rst_async_fifo: got data=%h valid=%b level=%0d uf=%b want 0000/0/0/0", oPix_Data, oPix_Valid, oFifo_Level, oUnderflow);
        end
        resp_on = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_stream();
        test_wrap();
        test_enable_freeze();
        test_frame_start_req();
        test_underflow();
        test_reset_mid_push();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
